// File: rtl/pipe_ctrl_pkg.sv
// Shared configuration for the pipeline hazard/sequencing controller:
// FSM encodings, reset polarity, datapath widths and control-bundle helpers.
package pipe_ctrl_pkg;

   localparam int   XLEN       = 32;
   localparam int   REG_W      = 5;
   localparam int   WAIT_W     = 8;
   localparam logic RST_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_hold;
      logic if_id_hold;
      logic id_ex_hold;
      logic ex_mem_hold;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // Freeze everything up to MEM and push a bubble into WB.
   function automatic ctrl_t ctrl_mem_wait();
      ctrl_t c;
      c = CTRL_IDLE;
      c.pc_hold      = 1'b1;
      c.if_id_hold   = 1'b1;
      c.id_ex_hold   = 1'b1;
      c.ex_mem_hold  = 1'b1;
      c.mem_wb_flush = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t ctrl_redirect();
      ctrl_t c;
      c = CTRL_IDLE;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t ctrl_flush();
      ctrl_t c;
      c = CTRL_IDLE;
      c.if_id_flush = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t ctrl_load_use();
      ctrl_t c;
      c = CTRL_IDLE;
      c.pc_hold     = 1'b1;
      c.if_id_hold  = 1'b1;
      c.id_ex_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_rs1_used && (id_rs1 == ex_rd);
   assign rs2_match = id_rs2_used && (id_rs2 == ex_rd);

   // x0 is hardwired to zero, so a load targeting it never produces a dependency.
   assign load_use = ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: priority mux of memory wait > redirect > load-use.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             id_ex_hold,
   output logic             ex_mem_hold,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout_err,
   output logic [XLEN-1:0]  stall_cnt,
   output logic [XLEN-1:0]  flush_cnt
);

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0]     FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(MEM_TIMEOUT);

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [FW-1:0]     flush_left, flush_left_nxt;
   logic              resume_flush, resume_flush_nxt;
   logic              err_set;
   logic              load_use;
   logic              mem_stall;
   logic              eval_run;
   logic              eval_flush;
   ctrl_t             ctrl;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_is_load  (ex_is_load),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   assign mem_stall = mem_req && !mem_ready;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      ctrl             = CTRL_IDLE;
      state_nxt        = state;
      wait_cnt_nxt     = wait_cnt;
      flush_left_nxt   = flush_left;
      resume_flush_nxt = resume_flush;
      err_set          = 1'b0;
      eval_run         = 1'b0;
      eval_flush       = 1'b0;

      case (state)
         RUN: begin
            if (mem_stall) begin
               ctrl             = ctrl_mem_wait();
               state_nxt        = MEM_WAIT;
               wait_cnt_nxt     = WAIT_W'(1);
               resume_flush_nxt = 1'b0;
            end else begin
               eval_run = 1'b1;
            end
         end
         FLUSH: begin
            // The flush counter stays frozen while memory stalls the pipe.
            if (mem_stall) begin
               ctrl             = ctrl_mem_wait();
               state_nxt        = MEM_WAIT;
               wait_cnt_nxt     = WAIT_W'(1);
               resume_flush_nxt = 1'b1;
            end else begin
               eval_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready || (wait_cnt >= WAIT_LIMIT)) begin
               err_set    = !mem_ready;
               eval_run   = !resume_flush;
               eval_flush = resume_flush;
            end else begin
               ctrl         = ctrl_mem_wait();
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      // Release cycles fall through here, so a redirect held in EX is serviced at once.
      if (eval_run || eval_flush) begin
         if (ex_redirect) begin
            ctrl = ctrl_redirect();
            if (FLUSH_CYCLES > 1) begin
               state_nxt      = FLUSH;
               flush_left_nxt = FLUSH_RELOAD;
            end else begin
               state_nxt = RUN;
            end
         end else if (eval_flush) begin
            ctrl           = ctrl_flush();
            flush_left_nxt = flush_left - FW'(1);
            state_nxt      = (flush_left == FW'(1)) ? RUN : FLUSH;
         end else begin
            state_nxt = RUN;
            if (load_use) begin
               ctrl = ctrl_load_use();
            end
         end
      end

      if (rst == RST_ACTIVE) begin
         ctrl = CTRL_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         state           <= RUN;
         wait_cnt        <= '0;
         flush_left      <= '0;
         resume_flush    <= 1'b0;
         mem_timeout_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         flush_left   <= flush_left_nxt;
         resume_flush <= resume_flush_nxt;
         if (err_set) begin
            mem_timeout_err <= 1'b1;
         end
      end
   end

   assign pc_hold      = ctrl.pc_hold;
   assign if_id_hold   = ctrl.if_id_hold;
   assign id_ex_hold   = ctrl.id_ex_hold;
   assign ex_mem_hold  = ctrl.ex_mem_hold;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_flush  = ctrl.id_ex_flush;
   assign mem_wb_flush = ctrl.mem_wb_flush;

`ifdef PIPE_CTRL_PERF_EN
   logic [XLEN-1:0] stall_q;
   logic [XLEN-1:0] flush_q;
   logic            redirect_accepted;

   // Only a serviced redirect flushes IF/ID and ID/EX together.
   assign redirect_accepted = ctrl.if_id_flush && ctrl.id_ex_flush;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_q + {{(XLEN-1){1'b0}}, ctrl.pc_hold};
         flush_q <= flush_q + {{(XLEN-1){1'b0}}, redirect_accepted};
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4): cycle script table
// with a scoreboard queue, plus hand sequences for reset and performance counters.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, mem_req, mem_ready;
   logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
   logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
   logic [31:0] stall_cnt, flush_cnt;
   logic [6:0]  ctrl_obs;

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
      .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign ctrl_obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_flush};

   // Expected control bundles: {pc_h, if_id_h, id_ex_h, ex_mem_h, if_id_f, id_ex_f, mem_wb_f}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] RD   = 7'b0000110;
   localparam logic [6:0] FL   = 7'b0000100;
   localparam logic [6:0] MW   = 7'b1111001;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] rs1;
      logic       rs1_used;
      logic [4:0] rs2;
      logic       rs2_used;
      logic       is_load;
      logic [4:0] rd;
      logic       redirect;
      logic       req;
      logic       ready;
   } in_t;

   typedef struct {
      string      name;
      logic [6:0] ctrl;
      logic       err;
   } exp_t;

   typedef struct {
      in_t  stim;
      exp_t exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic in_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic ld, input logic [4:0] rd,
                              input logic redir, input logic req, input logic rdy);
      in_t s;
      s.rs1 = rs1; s.rs1_used = u1; s.rs2 = rs2; s.rs2_used = u2;
      s.is_load = ld; s.rd = rd; s.redirect = redir; s.req = req; s.ready = rdy;
      return s;
   endfunction

   function automatic in_t idle();
      return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic in_t lu5();
      return mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic in_t mwait();
      return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic in_t mready();
      return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
   endfunction

   function automatic in_t redir();
      return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
   endfunction

   task automatic add(input string name, input in_t s, input logic [6:0] c, input logic e);
      vec_t v;
      v.stim = s; v.exp.name = name; v.exp.ctrl = c; v.exp.err = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t s);
      id_rs1 = s.rs1; id_rs1_used = s.rs1_used; id_rs2 = s.rs2; id_rs2_used = s.rs2_used;
      ex_is_load = s.is_load; ex_rd = s.rd; ex_redirect = s.redirect;
      mem_req = s.req; mem_ready = s.ready;
   endtask

   // Drive one cycle's inputs, queue the expectation, compare at the falling edge.
   task automatic step(input in_t s, input exp_t e);
      exp_t x;
      drive(s);
      sb.push_back(e);
      @(negedge clk);
      x = sb.pop_front();
      check({x.name, " ctrl"}, 32'(ctrl_obs), 32'(x.ctrl));
      check({x.name, " err"}, 32'(mem_timeout_err), 32'(x.err));
      @(posedge clk);
      #1;
   endtask

   task automatic step_x(input string name, input in_t s, input logic [6:0] c, input logic e);
      exp_t x;
      x.name = name; x.ctrl = c; x.err = e;
      step(s, x);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Cycle script; state carries from one entry to the next.
      add("idle0",            idle(), NONE, 1'b0);
      add("lu_rs1",           lu5(),  LU,   1'b0);
      add("lu_gone",          idle(), NONE, 1'b0);
      add("lu_x0",            mk(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), NONE, 1'b0);
      add("lu_rs2",           mk(5'd3, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), LU,   1'b0);
      add("rs2_unused",       mk(5'd3, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), NONE, 1'b0);
      add("not_load",         mk(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0), NONE, 1'b0);
      add("redir_c0",         redir(), RD,  1'b0);
      add("redir_c1",         idle(), FL,   1'b0);
      add("redir_c2",         idle(), NONE, 1'b0);
      add("redir_vs_lu",      mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), RD, 1'b0);
      add("redir_vs_lu_c1",   idle(), FL,   1'b0);
      add("mw_c0",            mwait(), MW,  1'b0);
      add("mw_c1",            mwait(), MW,  1'b0);
      add("mw_c2",            mwait(), MW,  1'b0);
      add("mw_release",       mready(), NONE, 1'b0);
      add("mem_hit",          mready(), NONE, 1'b0);
      add("mw_beats_all",     mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0), MW, 1'b0);
      add("mw_redir_held",    mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), MW, 1'b0);
      add("release_redir",    mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1), RD, 1'b0);
      add("release_redir_c1", idle(), FL,   1'b0);
      add("redir_b",          redir(), RD,  1'b0);
      add("flush_mw",         mwait(), MW,  1'b0);
      add("flush_mw_c1",      mwait(), MW,  1'b0);
      add("flush_resume",     mready(), FL, 1'b0);
      add("flush_done",       idle(), NONE, 1'b0);
      add("redir_c",          redir(), RD,  1'b0);
      add("redir_restart",    redir(), RD,  1'b0);
      add("restart_c1",       idle(), FL,   1'b0);
      add("restart_done",     idle(), NONE, 1'b0);
      add("to_c0",            mwait(), MW,  1'b0);
      add("to_c1",            mwait(), MW,  1'b0);
      add("to_c2",            mwait(), MW,  1'b0);
      add("to_c3",            mwait(), MW,  1'b0);
      add("to_release",       mwait(), NONE, 1'b0);
      add("to_sticky",        idle(), NONE, 1'b1);
      add("to_run_lu",        lu5(),  LU,   1'b1);

      // Reset state, with a load-use pattern on the inputs to show the outputs are gated.
      drive(lu5());
      #12;
      check("reset ctrl", 32'(ctrl_obs), 32'(NONE));
      check("reset err", 32'(mem_timeout_err), 32'd0);
      check("reset stall_cnt", stall_cnt, 32'd0);
      check("reset flush_cnt", flush_cnt, 32'd0);
      drive(idle());
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].stim, vecs[i].exp);
      end
      check("script stall_cnt", stall_cnt, PERF ? 32'd14 : 32'd0);
      check("script flush_cnt", flush_cnt, PERF ? 32'd6 : 32'd0);

      // Synchronous-looking reset pulse mid-cycle clears the sticky error and counters.
      rst = 1'b0;
      #1;
      check("rst2 err", 32'(mem_timeout_err), 32'd0);
      check("rst2 stall_cnt", stall_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Three-cycle memory wait with counters from a clean start.
      step_x("perf_mw_c0", mwait(), MW, 1'b0);
      step_x("perf_mw_c1", mwait(), MW, 1'b0);
      step_x("perf_mw_c2", mwait(), MW, 1'b0);
      step_x("perf_release", mready(), NONE, 1'b0);
      check("perf stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
      check("perf flush_cnt a", flush_cnt, 32'd0);
      step_x("perf_redir", redir(), RD, 1'b0);
      step_x("perf_redir_c1", idle(), FL, 1'b0);
      check("perf flush_cnt b", flush_cnt, PERF ? 32'd1 : 32'd0);
      check("perf stall_cnt b", stall_cnt, PERF ? 32'd3 : 32'd0);

      // Asynchronous reset in the middle of a MEM_WAIT cycle.
      step_x("arst_mw_c0", mwait(), MW, 1'b0);
      step_x("arst_mw_c1", mwait(), MW, 1'b0);
      #2;
      check("arst pre ctrl", 32'(ctrl_obs), 32'(MW));
      rst = 1'b0;
      #1;
      check("arst ctrl", 32'(ctrl_obs), 32'(NONE));
      check("arst stall_cnt", stall_cnt, 32'd0);
      drive(idle());
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      step_x("arst_run_idle", idle(), NONE, 1'b0);
      step_x("arst_run_lu", lu5(), LU, 1'b0);
      step_x("arst_run_after", idle(), NONE, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the five-stage core. Watches the ID, EX and MEM stages and drives the hold/flush controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, branch/jump redirects and multi-cycle data-memory waits with a fixed priority. Sits in CPU_CORE beside the stage registers and replaces the ad-hoc stall/flush wiring.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed per redirect (≥1; covers synchronous instruction-memory latency).
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before abort (1..255).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  5  destination of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch, jump or mispredict
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1 each  register keeps its value
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  register loads a bubble (zeros)
- mem_timeout_err  out  1  sticky; set on MEM_WAIT timeout
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state RUN; 8-bit wait counter and flush counter cleared.
- Outputs are Mealy (state + current inputs) and are sampled by the stage registers at the next edge.
- Priority in RUN: memory wait > redirect > load-use.
- Memory wait: mem_req=1 and mem_ready=0 → assert all four holds and mem_wb_flush; go to MEM_WAIT. mem_req=1 and mem_ready=1 → no action.
- MEM_WAIT: same outputs each cycle while mem_ready=0; wait counter increments. mem_ready=1 → drop holds this cycle and return to RUN. If the counter reaches MEM_TIMEOUT → set mem_timeout_err, return to RUN and release the holds.
- Redirect, RUN, no memory wait: assert if_id_flush and id_ex_flush; pc not held, so the target loads. FLUSH_CYCLES>1 → go to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH: assert if_id_flush only; decrement counter; return to RUN at 0. A memory wait arriving in FLUSH takes priority: freeze the counter and go to MEM_WAIT, then resume FLUSH. A new redirect restarts the counter.
- Load-use hazard: ex_is_load=1, ex_rd≠0, and (id_rs1_used and id_rs1==ex_rd, or id_rs2_used and id_rs2==ex_rd) → pc_hold, if_id_hold, id_ex_flush for exactly one cycle. No state is kept: the following cycle EX holds the bubble.
- Redirect coincident with load-use: redirect wins; there is no hold.
- Redirect pending during MEM_WAIT: EX is held, so ex_redirect stays stable and is serviced on the release cycle. Release and redirect occur in the same cycle.

## Timing
- Load-use costs 1 cycle; redirect costs FLUSH_CYCLES+1 cycles; a memory wait costs N cycles for N cycles of mem_ready=0.
- Every output asserts in the same cycle as its cause; there is no added latency.
- Reset (rst=0, asynchronous): all outputs 0, mem_timeout_err 0, counters 0, state RUN. Reset asserted mid-MEM_WAIT or mid-FLUSH aborts immediately.
- Hold and flush are never both asserted on the same register.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cnt increments on every cycle with pc_hold=1. flush_cnt increments once per accepted redirect. Both are 32-bit, wrap at 2^32, and are cleared by reset.
- PIPE_CTRL_PERF_EN undefined: no counter logic is built; stall_cnt and flush_cnt are tied to 0, and the ports remain.

## Structure
- FSM state encodings, reset polarity constant and XLEN go in the shared config header.
- One sub-module, hazard_detect: purely combinational load-use compare. pipe_ctrl holds the FSM, the counters and the output priority mux.

## Test plan
- Load x5 in EX, ID reads x5 (id_rs1_used=1) → one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1; all outputs 0 the next cycle. Same stimulus with ex_rd=0 → no hazard.
- ex_redirect for 1 cycle, FLUSH_CYCLES=2 → cycle 0: if_id_flush=1, id_ex_flush=1; cycle 1: if_id_flush=1 only; cycle 2: all outputs 0.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 → all holds and mem_wb_flush for 3 cycles, released on cycle 4; stall_cnt=3 with PIPE_CTRL_PERF_EN.
- mem_ready held 0, MEM_TIMEOUT=4 → holds for 4 cycles, then mem_timeout_err=1 (sticky) and state RUN.
- ex_redirect together with a load-use match → flushes only, no pc_hold. rst pulled low during MEM_WAIT → all outputs 0 asynchronously, state RUN after release.
